// File: rtl/wb_commit_unit_if.sv
// Interface for the writeback commit unit.
// MEM_* carries the completed-result bundle from the MEM stage.
// WB_* carries the register-file write ports and queue status.
interface wb_commit_unit_if #(
   parameter int CNT_W = 3
);
   // MEM-stage result bundle
   logic             MEM_v;
   logic [31:0]      MEM_dr1;
   logic [31:0]      MEM_dr2;
   logic [15:0]      MEM_dsegr;
   logic [63:0]      MEM_dmmx;
   logic [2:0]       MEM_dr1_sel;
   logic [2:0]       MEM_dr2_sel;
   logic [2:0]       MEM_dsegr_sel;
   logic [2:0]       MEM_dmmx_sel;
   logic             MEM_dr1_ld;
   logic             MEM_dr2_ld;
   logic             MEM_dsegr_ld;
   logic             MEM_dmmx_ld;
   logic             MEM_dr1_v;
   logic             MEM_dr2_v;
   logic             MEM_dsegr_v;
   logic             MEM_dmmx_v;
   logic [1:0]       MEM_dr1_type;
   logic [1:0]       MEM_dr2_type;
   logic             WB_flush;

   // Register-file write side and queue status
   logic             WB_ready;
   logic             WB_v;
   logic [31:0]      WB_dr1;
   logic [31:0]      WB_dr2;
   logic [15:0]      WB_dsegr;
   logic [63:0]      WB_dmmx;
   logic [2:0]       WB_dr1_sel;
   logic [2:0]       WB_dr2_sel;
   logic [2:0]       WB_dsegr_sel;
   logic [2:0]       WB_dmmx_sel;
   logic             WB_dr1_ld;
   logic             WB_dr2_ld;
   logic             WB_dsegr_ld;
   logic             WB_dmmx_ld;
   logic [1:0]       WB_dr1_type;
   logic [1:0]       WB_dr2_type;
   logic [CNT_W-1:0] WB_pending;

   // Producer side: MEM stage / flush source
   modport master (
      output MEM_v, MEM_dr1, MEM_dr2, MEM_dsegr, MEM_dmmx,
             MEM_dr1_sel, MEM_dr2_sel, MEM_dsegr_sel, MEM_dmmx_sel,
             MEM_dr1_ld, MEM_dr2_ld, MEM_dsegr_ld, MEM_dmmx_ld,
             MEM_dr1_v, MEM_dr2_v, MEM_dsegr_v, MEM_dmmx_v,
             MEM_dr1_type, MEM_dr2_type, WB_flush,
      input  WB_ready, WB_v, WB_dr1, WB_dr2, WB_dsegr, WB_dmmx,
             WB_dr1_sel, WB_dr2_sel, WB_dsegr_sel, WB_dmmx_sel,
             WB_dr1_ld, WB_dr2_ld, WB_dsegr_ld, WB_dmmx_ld,
             WB_dr1_type, WB_dr2_type, WB_pending
   );

   // Commit unit side
   modport slave (
      input  MEM_v, MEM_dr1, MEM_dr2, MEM_dsegr, MEM_dmmx,
             MEM_dr1_sel, MEM_dr2_sel, MEM_dsegr_sel, MEM_dmmx_sel,
             MEM_dr1_ld, MEM_dr2_ld, MEM_dsegr_ld, MEM_dmmx_ld,
             MEM_dr1_v, MEM_dr2_v, MEM_dsegr_v, MEM_dmmx_v,
             MEM_dr1_type, MEM_dr2_type, WB_flush,
      output WB_ready, WB_v, WB_dr1, WB_dr2, WB_dsegr, WB_dmmx,
             WB_dr1_sel, WB_dr2_sel, WB_dsegr_sel, WB_dmmx_sel,
             WB_dr1_ld, WB_dr2_ld, WB_dsegr_ld, WB_dmmx_ld,
             WB_dr1_type, WB_dr2_type, WB_pending
   );
endinterface

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: in-order writeback commit engine.
// Buffers MEM-stage result bundles and drives the GPR/segment/MMX write
// ports one instruction per cycle. When both GPR writes target the same
// register, the instruction takes a second cycle so that dr2 lands last.
module wb_commit_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic             CLK,
   input logic             CLR,
   wb_commit_unit_if.slave bus
);
   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef struct packed {
      logic [31:0] dr1;
      logic [31:0] dr2;
      logic [15:0] dsegr;
      logic [63:0] dmmx;
      logic [2:0]  dr1_sel;
      logic [2:0]  dr2_sel;
      logic [2:0]  dsegr_sel;
      logic [2:0]  dmmx_sel;
      logic [1:0]  dr1_type;
      logic [1:0]  dr2_type;
      logic        dr1_en;
      logic        dr2_en;
      logic        dsegr_en;
      logic        dmmx_en;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_SPLIT} state_t;

   entry_t           mem_q [DEPTH];
   entry_t           in_entry;
   entry_t           head;
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_t           state_q, state_d;
   logic             full, empty, conflict, push, pop;
   logic             wb_v, dr1_ld, dr2_ld, dsegr_ld, dmmx_ld;

   // The extra pointer bit distinguishes a full queue from an empty one.
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Pack the incoming bundle; a field with ld but not v is never written.
   always_comb begin
      in_entry           = '0;
      in_entry.dr1       = bus.MEM_dr1;
      in_entry.dr2       = bus.MEM_dr2;
      in_entry.dsegr     = bus.MEM_dsegr;
      in_entry.dmmx      = bus.MEM_dmmx;
      in_entry.dr1_sel   = bus.MEM_dr1_sel;
      in_entry.dr2_sel   = bus.MEM_dr2_sel;
      in_entry.dsegr_sel = bus.MEM_dsegr_sel;
      in_entry.dmmx_sel  = bus.MEM_dmmx_sel;
      in_entry.dr1_type  = bus.MEM_dr1_type;
      in_entry.dr2_type  = bus.MEM_dr2_type;
      in_entry.dr1_en    = bus.MEM_dr1_ld   & bus.MEM_dr1_v;
      in_entry.dr2_en    = bus.MEM_dr2_ld   & bus.MEM_dr2_v;
      in_entry.dsegr_en  = bus.MEM_dsegr_ld & bus.MEM_dsegr_v;
      in_entry.dmmx_en   = bus.MEM_dmmx_ld  & bus.MEM_dmmx_v;
   end

   // Commit sequencing, strobe generation and queue bookkeeping.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = 1'b0;
      wb_v     = 1'b0;
      dr1_ld   = 1'b0;
      dr2_ld   = 1'b0;
      dsegr_ld = 1'b0;
      dmmx_ld  = 1'b0;
      conflict = head.dr1_en && head.dr2_en && (head.dr1_sel == head.dr2_sel);
      push     = bus.MEM_v && !full;

      case (state_q)
         ST_COMMIT: begin
            wb_v     = 1'b1;
            dr1_ld   = head.dr1_en;
            dsegr_ld = head.dsegr_en;
            dmmx_ld  = head.dmmx_en;
            if (conflict) begin
               state_d = ST_SPLIT;
            end else begin
               dr2_ld = head.dr2_en;
               pop    = !empty;
            end
         end
         ST_SPLIT: begin
            wb_v   = 1'b1;
            dr2_ld = 1'b1;
            pop    = !empty;
         end
         default: ;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

      // Leaving a finished head (or idling): keep committing while entries remain.
      if (pop || state_q == ST_IDLE)
         state_d = (count_d != '0) ? ST_COMMIT : ST_IDLE;

      // Flush kills this cycle's writes and empties the queue at the edge.
      if (bus.WB_flush) begin
         push     = 1'b0;
         pop      = 1'b0;
         wb_v     = 1'b0;
         dr1_ld   = 1'b0;
         dr2_ld   = 1'b0;
         dsegr_ld = 1'b0;
         dmmx_ld  = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = ST_IDLE;
      end
   end

   // State, pointer and occupancy registers.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage written at the tail on an accepted bundle.
   // NOTE: the storage is reset because data/sel/type outputs read the head entry directly and must be 0 out of reset.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
      end
   end

   assign bus.WB_ready     = !full;
   assign bus.WB_pending   = count_q;
   assign bus.WB_v         = wb_v;
   assign bus.WB_dr1_ld    = dr1_ld;
   assign bus.WB_dr2_ld    = dr2_ld;
   assign bus.WB_dsegr_ld  = dsegr_ld;
   assign bus.WB_dmmx_ld   = dmmx_ld;
   assign bus.WB_dr1       = head.dr1;
   assign bus.WB_dr2       = head.dr2;
   assign bus.WB_dsegr     = head.dsegr;
   assign bus.WB_dmmx      = head.dmmx;
   assign bus.WB_dr1_sel   = head.dr1_sel;
   assign bus.WB_dr2_sel   = head.dr2_sel;
   assign bus.WB_dsegr_sel = head.dsegr_sel;
   assign bus.WB_dmmx_sel  = head.dmmx_sel;
   assign bus.WB_dr1_type  = head.dr1_type;
   assign bus.WB_dr2_type  = head.dr2_type;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Testbench for wb_commit_unit: directed scenarios followed by random
// traffic, checked against a schedule-of-writes reference model.
module tb_wb_commit_unit;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   typedef struct {
      logic [31:0] dr1, dr2;
      logic [15:0] seg;
      logic [63:0] mmx;
      logic [2:0]  dr1_sel, dr2_sel, seg_sel, mmx_sel;
      logic        dr1_ld, dr2_ld, seg_ld, mmx_ld;
      logic        dr1_v, dr2_v, seg_v, mmx_v;
      logic [1:0]  dr1_type, dr2_type;
   } bundle_t;

   // One register-file write cycle the DUT is expected to perform.
   typedef struct {
      bundle_t    b;
      logic [3:0] ld;     // {mmx, seg, dr2, dr1}
      bit         last;   // instruction retires after this cycle
   } wcyc_t;

   logic CLK = 1'b0;
   logic CLR;
   always #5 CLK = ~CLK;

   wb_commit_unit_if #(.CNT_W(CNT_W)) bus ();
   wb_commit_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

   int tests = 0;
   int fails = 0;

   wcyc_t       sched[$];
   int          n_ent;
   logic [31:0] m_gpr[8], d_gpr[8];
   logic [15:0] m_seg[8], d_seg[8];
   logic [63:0] m_mmx[8], d_mmx[8];
   bit          last_acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t idle_bundle();
      bundle_t b;
      b = '{default: '0};
      return b;
   endfunction

   function automatic bundle_t conflict_bundle(input int i);
      bundle_t b;
      b = idle_bundle();
      b.dr1 = 32'hC1000000 + i; b.dr2 = 32'hC2000000 + i;
      b.dr1_sel = 3'(i % 4); b.dr2_sel = 3'(i % 4);
      b.dr1_ld = 1; b.dr1_v = 1; b.dr2_ld = 1; b.dr2_v = 1;
      b.seg = 16'(i); b.seg_sel = 3'(4 + i % 4); b.seg_ld = 1; b.seg_v = 1;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.dr1 = $urandom; b.dr2 = $urandom; b.seg = 16'($urandom);
      b.mmx = {$urandom, $urandom};
      b.dr1_sel = 3'($urandom_range(0, 3)); b.dr2_sel = 3'($urandom_range(0, 3));
      b.seg_sel = 3'($urandom_range(0, 7)); b.mmx_sel = 3'($urandom_range(0, 7));
      b.dr1_ld = 1'($urandom); b.dr2_ld = 1'($urandom);
      b.seg_ld = 1'($urandom); b.mmx_ld = 1'($urandom);
      b.dr1_v = ($urandom_range(0, 3) != 0); b.dr2_v = ($urandom_range(0, 3) != 0);
      b.seg_v = ($urandom_range(0, 3) != 0); b.mmx_v = ($urandom_range(0, 3) != 0);
      b.dr1_type = 2'($urandom); b.dr2_type = 2'($urandom);
      return b;
   endfunction

   task automatic drive(input bundle_t b, input logic v, input logic fl);
      bus.MEM_v = v;            bus.WB_flush = fl;
      bus.MEM_dr1 = b.dr1;      bus.MEM_dr2 = b.dr2;
      bus.MEM_dsegr = b.seg;    bus.MEM_dmmx = b.mmx;
      bus.MEM_dr1_sel = b.dr1_sel; bus.MEM_dr2_sel = b.dr2_sel;
      bus.MEM_dsegr_sel = b.seg_sel; bus.MEM_dmmx_sel = b.mmx_sel;
      bus.MEM_dr1_ld = b.dr1_ld; bus.MEM_dr2_ld = b.dr2_ld;
      bus.MEM_dsegr_ld = b.seg_ld; bus.MEM_dmmx_ld = b.mmx_ld;
      bus.MEM_dr1_v = b.dr1_v;  bus.MEM_dr2_v = b.dr2_v;
      bus.MEM_dsegr_v = b.seg_v; bus.MEM_dmmx_v = b.mmx_v;
      bus.MEM_dr1_type = b.dr1_type; bus.MEM_dr2_type = b.dr2_type;
   endtask

   // Expand an accepted instruction into its write cycles.
   task automatic model_enqueue(input bundle_t raw);
      bundle_t b;
      wcyc_t   c;
      b = raw;
      b.dr1_ld = raw.dr1_ld & raw.dr1_v; b.dr2_ld = raw.dr2_ld & raw.dr2_v;
      b.seg_ld = raw.seg_ld & raw.seg_v; b.mmx_ld = raw.mmx_ld & raw.mmx_v;
      c.b = b;
      if (b.dr1_ld && b.dr2_ld && b.dr1_sel == b.dr2_sel) begin
         c.ld = {b.mmx_ld, b.seg_ld, 1'b0, 1'b1}; c.last = 0; sched.push_back(c);
         c.ld = 4'b0010;                          c.last = 1; sched.push_back(c);
      end else begin
         c.ld = {b.mmx_ld, b.seg_ld, b.dr2_ld, b.dr1_ld}; c.last = 1; sched.push_back(c);
      end
      n_ent++;
   endtask

   task automatic model_edge(input bundle_t b, input bit acc, input logic fl);
      wcyc_t c;
      if (fl) begin
         sched.delete();
         n_ent = 0;
      end else begin
         if (sched.size() > 0) begin
            c = sched.pop_front();
            if (c.ld[0]) m_gpr[c.b.dr1_sel] = c.b.dr1;
            if (c.ld[1]) m_gpr[c.b.dr2_sel] = c.b.dr2;
            if (c.ld[2]) m_seg[c.b.seg_sel] = c.b.seg;
            if (c.ld[3]) m_mmx[c.b.mmx_sel] = c.b.mmx;
            if (c.last) n_ent--;
         end
         if (acc) model_enqueue(b);
      end
   endtask

   task automatic check_outputs(input logic fl);
      logic [3:0] exp_ld;
      exp_ld = 4'b0000;
      if (sched.size() > 0 && !fl) exp_ld = sched[0].ld;
      check("WB_v", bus.WB_v, sched.size() > 0 && !fl);
      check("strobes", {bus.WB_dmmx_ld, bus.WB_dsegr_ld, bus.WB_dr2_ld, bus.WB_dr1_ld}, exp_ld);
      check("WB_ready", bus.WB_ready, n_ent < DEPTH);
      check("WB_pending", bus.WB_pending, 64'(n_ent));
      if (sched.size() > 0) begin
         check("head dr1", bus.WB_dr1, sched[0].b.dr1);
         check("head dr2", bus.WB_dr2, sched[0].b.dr2);
         check("head mmx", bus.WB_dmmx, sched[0].b.mmx);
         check("head seg/sel/type",
               {bus.WB_dsegr, bus.WB_dr1_sel, bus.WB_dr2_sel, bus.WB_dsegr_sel, bus.WB_dmmx_sel,
                bus.WB_dr1_type, bus.WB_dr2_type},
               {sched[0].b.seg, sched[0].b.dr1_sel, sched[0].b.dr2_sel, sched[0].b.seg_sel,
                sched[0].b.mmx_sel, sched[0].b.dr1_type, sched[0].b.dr2_type});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " WB_v"}, bus.WB_v, 0);
      check({tag, " strobes"}, {bus.WB_dmmx_ld, bus.WB_dsegr_ld, bus.WB_dr2_ld, bus.WB_dr1_ld}, 0);
      check({tag, " WB_ready"}, bus.WB_ready, 1);
      check({tag, " WB_pending"}, bus.WB_pending, 0);
      check({tag, " data"}, {bus.WB_dr1, bus.WB_dr2}, 0);
      check({tag, " mmx"}, bus.WB_dmmx, 0);
      check({tag, " seg/sel/type"},
            {bus.WB_dsegr, bus.WB_dr1_sel, bus.WB_dr2_sel, bus.WB_dsegr_sel, bus.WB_dmmx_sel,
             bus.WB_dr1_type, bus.WB_dr2_type}, 0);
   endtask

   // Record what the DUT actually writes into a shadow register file.
   task automatic capture_writes();
      if (bus.WB_dr1_ld === 1'b1) d_gpr[bus.WB_dr1_sel] = bus.WB_dr1;
      if (bus.WB_dr2_ld === 1'b1) d_gpr[bus.WB_dr2_sel] = bus.WB_dr2;
      if (bus.WB_dsegr_ld === 1'b1) d_seg[bus.WB_dsegr_sel] = bus.WB_dsegr;
      if (bus.WB_dmmx_ld === 1'b1) d_mmx[bus.WB_dmmx_sel] = bus.WB_dmmx;
   endtask

   // One clock cycle: drive at the falling edge, check, then model the rising edge.
   task automatic step(input bundle_t b, input logic v, input logic fl);
      bit rdy;
      drive(b, v, fl);
      #1;
      check_outputs(fl);
      capture_writes();
      rdy      = (n_ent < DEPTH);
      last_acc = v && rdy && !fl;
      @(posedge CLK);
      model_edge(b, last_acc, fl);
      @(negedge CLK);
   endtask

   initial begin
      bundle_t b;
      int      i, guard;
      bit      saw_full;
      logic [2:0]  t5_sel;
      logic [31:0] t5_val;

      for (int r = 0; r < 8; r++) begin
         m_gpr[r] = '0; d_gpr[r] = '0; m_seg[r] = '0; d_seg[r] = '0; m_mmx[r] = '0; d_mmx[r] = '0;
      end
      n_ent = 0;
      CLR = 1'b0;
      drive(idle_bundle(), 1'b0, 1'b0);
      @(negedge CLK);
      check_reset_outputs("reset");
      CLR = 1'b1;

      // 1: single bundle, one-cycle latency
      b = idle_bundle();
      b.dr1 = 32'h12345678; b.dr1_sel = 3'd3; b.dr1_type = 2'd2; b.dr1_ld = 1; b.dr1_v = 1;
      step(b, 1, 0);
      step(idle_bundle(), 0, 0);
      step(idle_bundle(), 0, 0);
      check("t1 gpr3", d_gpr[3], 32'h12345678);

      // 2: same-register conflict splits, dr2 lands last
      b = idle_bundle();
      b.dr1 = 32'hAAAA0000; b.dr1_sel = 3'd2; b.dr1_ld = 1; b.dr1_v = 1;
      b.dr2 = 32'h0000BBBB; b.dr2_sel = 3'd2; b.dr2_ld = 1; b.dr2_v = 1;
      b.seg = 16'h5A5A;     b.seg_sel = 3'd1; b.seg_ld = 1; b.seg_v = 1;
      step(b, 1, 0);
      for (int k = 0; k < 3; k++) step(idle_bundle(), 0, 0);
      check("t2 gpr2", d_gpr[2], 32'h0000BBBB);
      check("t2 seg1", d_seg[1], 16'h5A5A);

      // 3: back-to-back pushes fill the queue; upstream holds while full
      saw_full = 0; i = 0; guard = 0;
      while (i < 8 && guard < 100) begin
         step(conflict_bundle(i), 1, 0);
         if (last_acc) i++;
         if (bus.WB_ready === 1'b0) saw_full = 1;
         guard++;
      end
      check("t3 all accepted", i, 8);
      check("t3 ready dropped", saw_full, 1);
      for (int k = 0; k < 12; k++) step(idle_bundle(), 0, 0);

      // 4: ld without v on dmmx is never written
      b = idle_bundle();
      b.dr1 = 32'h44440001; b.dr1_sel = 3'd5; b.dr1_ld = 1; b.dr1_v = 1;
      b.mmx = 64'hDEADBEEF_CAFEF00D; b.mmx_sel = 3'd6; b.mmx_ld = 1; b.mmx_v = 0;
      step(b, 1, 0);
      step(idle_bundle(), 0, 0);
      check("t4 mmx6 untouched", d_mmx[6], 64'h0);
      check("t4 gpr5", d_gpr[5], 32'h44440001);

      // 5: flush during SPLIT with 3 entries queued
      i = 100; guard = 0;
      while (!(sched.size() > 0 && !sched[0].ld[0] && sched[0].ld[1] && n_ent >= 3) && guard < 50) begin
         step(conflict_bundle(i), 1, 0);
         if (last_acc) i++;
         guard++;
      end
      check("t5 reached split", guard < 50, 1);
      t5_sel = sched[0].b.dr2_sel;
      t5_val = sched[0].b.dr1;
      step(conflict_bundle(i), 1, 1);
      check("t5 pending cleared", bus.WB_pending, 0);
      check("t5 ready", bus.WB_ready, 1);
      step(idle_bundle(), 0, 0);
      check("t5 dr2 not written", d_gpr[t5_sel], t5_val);

      // 6: asynchronous reset in the middle of a commit cycle
      b = idle_bundle();
      b.dr2 = 32'h66660002; b.dr2_sel = 3'd7; b.dr2_ld = 1; b.dr2_v = 1;
      step(b, 1, 0);
      drive(idle_bundle(), 0, 0);
      #1;
      check("t6 committing", bus.WB_v, 1);
      #2 CLR = 1'b0;
      #1;
      check("t6 kill WB_v", bus.WB_v, 0);
      check("t6 kill dr2_ld", bus.WB_dr2_ld, 0);
      sched.delete(); n_ent = 0;
      @(posedge CLK);
      @(negedge CLK);
      CLR = 1'b1;
      #1;
      check_reset_outputs("t6 after release");
      step(b, 1, 0);
      step(idle_bundle(), 0, 0);
      check("t6 gpr7", d_gpr[7], 32'h66660002);

      // Random traffic
      for (int k = 0; k < 400; k++)
         step(rand_bundle(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      for (int k = 0; k < 12; k++) step(idle_bundle(), 0, 0);

      // Final register-file state against the model
      for (int r = 0; r < 8; r++) begin
         check($sformatf("final gpr%0d", r), d_gpr[r], m_gpr[r]);
         check($sformatf("final seg%0d", r), d_seg[r], m_seg[r]);
         check($sformatf("final mmx%0d", r), d_mmx[r], m_mmx[r]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
